// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: state encoding and default width.
package interval_timer_pkg;

    localparam int unsigned N_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_EXPIRED = 2'b10
    } state_e;

endpackage : interval_timer_pkg

// File: rtl/CmpN_M.sv
// Constant-equality comparator: match_o is high when value_i equals the constant M.
module CmpN_M #(
    parameter int unsigned N = 32,
    parameter int unsigned M = 0
) (
    input  logic [N-1:0] value_i,
    output logic         match_o
);

    localparam logic [N-1:0] REF_VAL = N'(M);

    // Pure compare against the elaboration-time constant
    assign match_o = (value_i == REF_VAL);

endmodule : CmpN_M

// File: rtl/interval_timer.sv
// One-shot / periodic down-counting interval timer with Done handshake and overrun flag.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Start,
    input  logic [N-1:0] Load_val,
    input  logic         Auto_reload,
    input  logic         Ack,
    input  logic         Abort,
    output logic [N-1:0] Cnt_out,
    output logic         Busy,
    output logic         Done,
    output logic         Overrun
);

    state_e       state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_q, period_d;
    logic         reload_q, reload_d;
    logic         overrun_q, overrun_d;

    logic         cnt_is_one;
    logic         cnt_is_zero;
    logic         load_is_zero;
    logic [N-1:0] cnt_step;

    CmpN_M #(.N(N), .M(1)) u_cmp_cnt_one (
        .value_i (cnt_q),
        .match_o (cnt_is_one)
    );

    CmpN_M #(.N(N), .M(0)) u_cmp_load_zero (
        .value_i (Load_val),
        .match_o (load_is_zero)
    );

    assign cnt_is_zero = (cnt_q == '0);

    // Counter step: periodic mode reloads at zero, otherwise decrement and saturate at zero
    always_comb begin
        cnt_step = cnt_q;
        if (cnt_is_zero) begin
            cnt_step = reload_q ? period_q : '0;
        end else begin
            cnt_step = cnt_q - N'(1);
        end
    end

    // Next-state logic; Abort overrides every other request
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        reload_d  = reload_q;
        overrun_d = overrun_q;

        if (Abort) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        overrun_d = 1'b0;
                        if (load_is_zero) begin
                            cnt_d    = '0;
                            reload_d = 1'b0;
                            state_d  = ST_EXPIRED;
                        end else begin
                            cnt_d    = Load_val;
                            period_d = Load_val;
                            reload_d = Auto_reload;
                            state_d  = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_d = cnt_step;
                    if (cnt_is_one) begin
                        state_d = ST_EXPIRED;
                    end
                end
                ST_EXPIRED: begin
                    if (!reload_q) begin
                        cnt_d = '0;
                        if (Ack) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Counter keeps running; an unacked Done about to be re-hit is an overrun
                        cnt_d = cnt_step;
                        if (Ack && !cnt_is_one) begin
                            state_d = ST_RUN;
                        end else if (!Ack && cnt_is_one) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, count, period, reload mode and overrun registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            reload_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            reload_q  <= reload_d;
            overrun_q <= overrun_d;
        end
    end

    assign Cnt_out = cnt_q;
    assign Busy    = (state_q != ST_IDLE);
    assign Done    = (state_q == ST_EXPIRED);
    assign Overrun = overrun_q;

endmodule : interval_timer

// File: tb/tb_interval_timer.sv
// Scoreboard bench for interval_timer: driver pushes model predictions, monitor compares each cycle.
module tb_interval_timer;

    localparam int unsigned TB_N = 8;

    typedef struct packed {
        logic [TB_N-1:0] cnt;
        logic            busy;
        logic            done;
        logic            ovr;
    } obs_t;

    logic            Clk = 1'b0;
    logic            Rst_n = 1'b0;
    logic            Start = 1'b0;
    logic [TB_N-1:0] Load_val = '0;
    logic            Auto_reload = 1'b0;
    logic            Ack = 1'b0;
    logic            Abort = 1'b0;
    logic [TB_N-1:0] Cnt_out;
    logic            Busy;
    logic            Done;
    logic            Overrun;

    int    checks = 0;
    int    failures = 0;
    obs_t  exp_q[$];
    string phase = "init";

    // Reference model: timer described by elapsed cycles since Start and a pending-Done flag
    bit m_active   = 1'b0;
    bit m_periodic = 1'b0;
    bit m_done     = 1'b0;
    bit m_ovr      = 1'b0;
    int m_len      = 0;
    int m_k        = 0;
    int m_cnt      = 0;

    interval_timer #(.N(TB_N)) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .Start       (Start),
        .Load_val    (Load_val),
        .Auto_reload (Auto_reload),
        .Ack         (Ack),
        .Abort       (Abort),
        .Cnt_out     (Cnt_out),
        .Busy        (Busy),
        .Done        (Done),
        .Overrun     (Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        m_active = 1'b0; m_periodic = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
        m_len = 0; m_k = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input int lv, input bit ar, input bit ak, input bit ab);
        int ncnt;
        if (ab) begin
            m_active = 1'b0; m_done = 1'b0; m_ovr = 1'b0; m_cnt = 0;
        end else if (!m_active) begin
            if (st) begin
                m_active = 1'b1; m_ovr = 1'b0; m_k = 0; m_len = lv;
                if (lv == 0) begin
                    m_periodic = 1'b0; m_done = 1'b1; m_cnt = 0;
                end else begin
                    m_periodic = ar; m_done = 1'b0; m_cnt = lv;
                end
            end
        end else if (!m_periodic) begin
            if (m_done) begin
                if (ak) begin
                    m_active = 1'b0; m_done = 1'b0;
                end
            end else begin
                m_k   = m_k + 1;
                m_cnt = m_len - m_k;
                m_done = (m_cnt == 0);
            end
        end else begin
            // Periodic: count is L - (elapsed mod (L+1)) regardless of acknowledgements
            m_k  = (m_k + 1) % (m_len + 1);
            ncnt = m_len - m_k;
            if (m_done && !ak && m_cnt == 1) m_ovr = 1'b1;
            m_done = (ncnt == 0) || (m_done && !ak);
            m_cnt  = ncnt;
        end
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.cnt  = TB_N'(m_cnt);
        o.busy = m_active;
        o.done = m_done;
        o.ovr  = m_ovr;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp_v);
        obs_t act;
        act = {Cnt_out, Busy, Done, Overrun};
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s @%0t: got cnt=%0d busy=%b done=%b ovr=%b, want cnt=%0d busy=%b done=%b ovr=%b",
                     name, $time, act.cnt, act.busy, act.done, act.ovr,
                     exp_v.cnt, exp_v.busy, exp_v.done, exp_v.ovr);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue the predicted post-edge outputs
    task automatic cycle(input bit st, input int lv, input bit ar, input bit ak, input bit ab);
        @(negedge Clk);
        Start = st; Load_val = TB_N'(lv); Auto_reload = ar; Ack = ak; Abort = ab;
        model_step(st, lv, ar, ak, ab);
        exp_q.push_back(model_obs());
    endtask

    task automatic apply_reset();
        @(negedge Clk);
        Rst_n = 1'b0; Start = 1'b0; Ack = 1'b0; Abort = 1'b0; Auto_reload = 1'b0; Load_val = '0;
        #1;
        check_obs({phase, "_async_reset"}, '0);
        model_reset();
        exp_q.push_back('0);
        @(negedge Clk);
        Rst_n = 1'b1;
        exp_q.push_back('0);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction after every rising edge
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) check_obs(phase, exp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  r;
        bit  st, ar, ak, ab;
        int  lv;

        #1;
        check_obs("power_on_reset", '0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;

        phase = "oneshot_L5";
        cycle(1, 5, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);

        phase = "load_zero";
        cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        phase = "periodic_acked";
        cycle(1, 3, 1, 0, 0);
        repeat (16) cycle(0, 0, 0, m_done, 0);
        cycle(0, 0, 0, 0, 1);

        phase = "periodic_overrun";
        cycle(1, 3, 1, 0, 0);
        repeat (10) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        phase = "ack_at_one";
        cycle(1, 2, 1, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);

        phase = "ignored_start_ack";
        cycle(0, 0, 0, 1, 0);
        cycle(1, 4, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(1, 9, 1, 0, 0);
        repeat (4) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);

        phase = "max_load";
        cycle(1, 255, 0, 0, 0);
        repeat (258) cycle(0, 0, 0, 0, 0);
        cycle(1, 7, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        phase = "start_abort_reset";
        cycle(0, 0, 0, 0, 1);
        cycle(1, 10, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(1, 10, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        apply_reset();
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                apply_reset();
            end else begin
                st = ($urandom_range(0, 3) == 0);
                lv = ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 6));
                ar = ($urandom_range(0, 1) == 1);
                ak = m_done ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
                ab = ($urandom_range(0, 39) == 0);
                cycle(st, lv, ar, ak, ab);
            end
        end
        cycle(0, 0, 0, 0, 0);

        phase = "drain";
        repeat (3) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_interval_timer

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named Clk and Rst_n.
REQ-002 Parameter N SHALL default to 32 and SHALL set the count width; legal range is 2..32.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Rst_n  input  1  asynchronous active-low reset.
REQ-005 Start  input  1  load request; sampled only in IDLE.
REQ-006 Load_val  input  N  interval length L, captured with Start.
REQ-007 Auto_reload  input  1  periodic-mode select, captured with Start.
REQ-008 Ack  input  1  consumer acknowledge of Done.
REQ-009 Abort  input  1  synchronous cancel, valid in any state.
REQ-010 Cnt_out  output  N  current count, registered; drives downstream constant comparators.
REQ-011 Busy  output  1  high whenever the state is not IDLE.
REQ-012 Done  output  1  terminal-count flag, held until Ack.
REQ-013 Overrun  output  1  sticky flag: a periodic terminal event was missed.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and EXPIRED; Busy SHALL equal (state != IDLE) and Done SHALL equal (state == EXPIRED), both decoded from registered state.
REQ-015 IDLE, Start=1, L>=1: on the next edge the block SHALL set Cnt_out=L, store Period=L, store Reload=Auto_reload, clear Overrun, and enter RUN.
REQ-016 IDLE, Start=1, L=0: on the next edge the block SHALL set Cnt_out=0, force Reload=0, and enter EXPIRED.
REQ-017 RUN: Cnt_out SHALL decrement by 1 per cycle; when Cnt_out==1, the next edge SHALL give Cnt_out=0 and enter EXPIRED; the latency from Start to Done SHALL be L+1 cycles.
REQ-018 EXPIRED, Reload=0: Cnt_out SHALL hold 0; Ack SHALL return the block to IDLE on the next edge.
REQ-019 EXPIRED or RUN, Reload=1: when Cnt_out==0, the next value SHALL be Period, otherwise Cnt_out-1, giving a terminal period of L+1 cycles.
REQ-020 EXPIRED, Reload=1, Ack=1: the block SHALL go to RUN unless Cnt_out==1 in the same cycle, in which case it SHALL stay in EXPIRED with no Overrun.
REQ-021 EXPIRED, Reload=1, Ack=0, Cnt_out==1: Overrun SHALL set on the next edge and stay set until Abort, an accepted Start, or reset.
REQ-022 Start outside IDLE SHALL be ignored, and Ack outside EXPIRED SHALL be ignored.
REQ-023 Abort SHALL take priority over Start, Ack and counting: on the next edge state=IDLE, Cnt_out=0, Overrun=0.
REQ-024 Count arithmetic SHALL be unsigned N-bit; Cnt_out SHALL never wrap below 0.

Reset
REQ-025 While Rst_n=0, asynchronously: state=IDLE, Cnt_out=0, Period=0, Reload=0, Overrun=0, and therefore Busy=0 and Done=0.
REQ-026 Reset asserted mid-count SHALL discard the interval; after release the block SHALL wait for a new Start.

Structure
REQ-027 The state encoding (IDLE=2'b00, RUN=2'b01, EXPIRED=2'b10) and the default N SHALL live in the shared package.
REQ-028 Terminal detection SHALL use the existing constant-equality comparator CmpN_M: one instance with M=1 on Cnt_out, and one with M=0 on Load_val for the zero-load check.
REQ-029 The block SHALL have a single registered process for state, Cnt_out, Period, Reload and Overrun, with combinational next-state logic.

Verification
REQ-030 Start, L=5, Auto_reload=0 -> Cnt_out 5,4,3,2,1,0; Done=1 at cycle 6; Ack -> IDLE, Busy=0 next cycle.
REQ-031 Start, L=0 -> Done=1 and Cnt_out=0 after 1 cycle; Ack -> IDLE.
REQ-032 Start, L=3, Auto_reload=1, Ack asserted in each EXPIRED cycle -> Done pulses every 4 cycles with Overrun=0.
REQ-033 Start, L=3, Auto_reload=1, no Ack -> Overrun=1 four cycles after the first Done; Abort -> Overrun=0, Cnt_out=0, state IDLE.
REQ-034 Start and Abort in the same cycle, then Rst_n low at count 7 of L=10 -> Abort wins (stays IDLE); after reset, all outputs are 0 and a later Start is accepted.
